// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the decryption round datapath.
//   AES_BLOCK_BYTES : bytes per AES state (16)
//   aes_state_t     : 128-bit state, byte 0 in bits [127:120]
//   inv_sb_fsm_e    : control states of the InvSubBytes sequencer
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } inv_sb_fsm_e;

endpackage

// File: rtl/aes_inv_sbox.sv
// ---------------------------------------------------------------------------
// aes_inv_sbox
// Purely combinational AES inverse S-box for one byte.
//   data_i : input byte
//   data_o : InvSubBytes(data_i)
// The byte first goes through the inverse affine transform, and then the
// multiplicative inverse in GF(2^8) is taken. The inverse is x^254, built
// from seven squarings, so that 0 maps to 0 without a special case.
// ---------------------------------------------------------------------------
module aes_inv_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // GF(2^8) multiply, reduction polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = product of x^(2^i) for i = 1..7.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] affine_inv;

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  assign affine_inv = {data_i[6:0], data_i[7]}
                    ^ {data_i[4:0], data_i[7:5]}
                    ^ {data_i[1:0], data_i[7:2]}
                    ^ 8'h05;

  assign data_o = gf_inv(affine_inv);

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// aes_inv_sub_bytes_seq
// Applies InvSubBytes to a 128-bit AES state using LANES inverse S-boxes,
// substituting LANES bytes per cycle in ascending byte order.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_state captured on accept
//   in_state            : state, byte k = in_state[127-8k -: 8]
//   out_valid/out_ready : output handshake for out_state
//   out_state           : substituted state (meaningful while out_valid)
//   busy                : high while a block is in RUN or DONE
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; both
// are decodes of the registered state, so neither depends combinationally
// on in_valid or out_ready. out_state is held while out_valid && !out_ready.
// ---------------------------------------------------------------------------
module aes_inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("aes_inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int NBEATS = AES_BLOCK_BYTES / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  inv_sb_fsm_e       state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  aes_state_t        work_q, work_d;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  // Lane l sees byte beat*LANES+l; every index is a constant after unrolling.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = 8'h00;
      for (int b = 0; b < NBEATS; b++) begin
        if (beat_q == BEAT_W'(b)) lane_in[l] = work_q[127 - 8*(b*LANES + l) -: 8];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_inv_sbox u_sbox (
      .data_i (lane_in[l]),
      .data_o (lane_out[l])
    );
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          beat_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Byte k belongs to beat k/LANES and lane k%LANES.
        for (int k = 0; k < AES_BLOCK_BYTES; k++) begin
          if (beat_q == BEAT_W'(k / LANES)) work_d[127 - 8*k -: 8] = lane_out[k % LANES];
        end
        if (beat_q == BEAT_W'(NBEATS - 1)) state_d = DONE;
        else                                beat_d  = beat_q + 1'b1;
      end
      DONE: begin
        // in_valid is deliberately not looked at here: a new block can only
        // be accepted from IDLE, one cycle later.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_state = work_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_sub_bytes_seq
// Five instances (LANES = 1, 2, 4, 8, 16) share one stimulus stream. Each
// instance has its own monitor with an expected queue filled at accept time
// from a table-driven inverse S-box model. The table is obtained by building
// the forward S-box from its field definition and inverting it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_inv_sub_bytes_seq;

  localparam int NCFG = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             out_ready;
  logic [127:0]     in_state;
  logic [NCFG-1:0]  in_ready;
  logic [NCFG-1:0]  out_valid;
  logic [NCFG-1:0]  busy;
  logic [127:0]     out_state [NCFG];
  logic [127:0]     last_out  [NCFG];
  int               pend      [NCFG];
  logic [7:0]       inv_tab   [256];
  bit               rand_stall = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_table();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      logic [7:0] s;
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = inv_tab[s[127 - 8*k -: 8]];
    return r;
  endfunction

  // ---------------- DUTs + monitors ----------------
  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int LANES  = 1 << g;
    localparam int NBEATS = 16 / LANES;

    logic [127:0] exp_q [$];
    logic [127:0] prev_state = '0;
    bit           prev_stall = 1'b0;
    bit           tracking   = 1'b0;
    int           lat        = 0;

    aes_inv_sub_bytes_seq #(.LANES(LANES)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_state  (in_state),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        tracking   = 1'b0;
        prev_stall = 1'b0;
        check($sformatf("reset_out_valid L%0d", LANES), 128'(out_valid[g]), 128'(0));
        check($sformatf("reset_out_state L%0d", LANES), out_state[g], 128'(0));
      end else begin
        if (tracking) begin
          lat++;
          if (out_valid[g]) begin
            check($sformatf("latency L%0d", LANES), 128'(lat), 128'(NBEATS));
            tracking = 1'b0;
          end else if (lat > NBEATS) begin
            check($sformatf("latency_timeout L%0d", LANES), 128'(lat), 128'(NBEATS));
            tracking = 1'b0;
          end
        end
        if (prev_stall) begin
          check($sformatf("stall_valid L%0d", LANES), 128'(out_valid[g]), 128'(1));
          check($sformatf("stall_state L%0d", LANES), out_state[g], prev_state);
        end
        if (out_valid[g]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("spurious_out_valid L%0d", LANES), 128'(out_valid[g]), 128'(0));
          end else if (out_ready) begin
            check($sformatf("data L%0d", LANES), out_state[g], exp_q.pop_front());
            last_out[g] = out_state[g];
          end
        end
        prev_stall = out_valid[g] && !out_ready;
        prev_state = out_state[g];
        if (in_valid && in_ready[g]) begin
          exp_q.push_back(ref_inv(in_state));
          tracking = 1'b1;
          lat      = -1;
        end
      end
      pend[g] = exp_q.size();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [127:0] s);
    int n;
    n = 0;
    while (in_ready != '1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) bound_fail("send_wait_in_ready");
    in_state = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy != '0 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) bound_fail("drain_wait_idle");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] snap [NCFG];
    logic [127:0] s;
    int           n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_state  = '0;
    for (int i = 0; i < NCFG; i++) last_out[i] = '0;
    build_table();

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("post_reset_in_ready %0d", i),  128'(in_ready[i]),  128'(1));
      check($sformatf("post_reset_out_valid %0d", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("post_reset_busy %0d", i),      128'(busy[i]),      128'(0));
      check($sformatf("post_reset_out_state %0d", i), out_state[i],       128'(0));
    end
    tick();

    // Uniform inputs, LANES = 4 instance.
    send({16{8'h63}});
    drain();
    check("uniform_63", last_out[2], {16{8'h00}});
    send({16{8'h00}});
    drain();
    check("uniform_00", last_out[2], {16{8'h52}});

    // Byte order on every lane count.
    send({4{32'h00ff637c}});
    drain();
    for (int i = 0; i < NCFG; i++)
      check($sformatf("byte_order %0d", i), last_out[i], {4{32'h527d0001}});

    // Backpressure in DONE while in_valid toggles.
    out_ready = 1'b0;
    send({$urandom(), $urandom(), $urandom(), $urandom()});
    n = 0;
    while (out_valid != '1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) bound_fail("bp_wait_out_valid");
    for (int i = 0; i < NCFG; i++) snap[i] = out_state[i];
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2 == 0);
      in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_out_valid", 128'(out_valid), 128'(5'h1f));
      for (int i = 0; i < NCFG; i++)
        check($sformatf("bp_out_state %0d", i), out_state[i], snap[i]);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    check("bp_release_in_ready", 128'(in_ready), 128'(5'h1f));
    check("bp_release_busy", 128'(busy), 128'(0));
    check("bp_release_out_valid", 128'(out_valid), 128'(0));
    in_valid = 1'b0;
    tick();

    // Reset during RUN beat 2 of the LANES = 1 instance.
    send({$urandom(), $urandom(), $urandom(), $urandom()});
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("after_reset_no_valid", 128'(out_valid), 128'(0));
    end
    send({16{8'h63}});
    drain();
    check("after_reset_block", last_out[0], {16{8'h00}});

    // All 256 byte values, then random blocks, with random output stalls.
    rand_stall = 1'b1;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) s[127 - 8*k -: 8] = 8'(16*b + k);
      send(s);
    end
    for (int r = 0; r < 12; r++) send({$urandom(), $urandom(), $urandom(), $urandom()});
    rand_stall = 1'b0;
    out_ready  = 1'b1;
    drain();
    tick();
    for (int i = 0; i < NCFG; i++)
      check($sformatf("queue_empty %0d", i), 128'(pend[i]), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_sub_bytes_seq.md
# aes_inv_sub_bytes_seq

Sequencer that applies InvSubBytes to a full 128-bit AES state by time-multiplexing a small, parameterised number of `aes_inv_sbox` instances across the 16 state bytes. It sits in the decryption round datapath between InvShiftRows and AddRoundKey. It trades latency for area: LANES bytes are substituted per cycle. Both input and output use a valid/ready handshake.

## Interface
Parameters:
- LANES, default 4: number of `aes_inv_sbox` instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16. Elaboration fails on any other value.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block accepts a new state.
- in_state  input  128  ciphertext-round state; byte k = in_state[127-8k -: 8], byte 0 is the MSB.
- out_valid  output  1  out_state holds the fully substituted result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  substituted state, same byte ordering as in_state.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- Datapath registers:
  - 128-bit working register `work`.
  - Beat counter `beat`, width clog2(16/LANES) with a minimum of 1 bit; NBEATS = 16/LANES.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: `work` <= in_state, `beat` <= 0, go to RUN.
- RUN:
  - Each cycle, bytes beat*LANES … beat*LANES+LANES-1 of `work` pass through sbox lanes 0…LANES-1 and are written back in place. All other bytes hold.
  - If beat == NBEATS-1, go to DONE. Otherwise beat <= beat+1.
  - Byte processing order is ascending (byte 0 first).
- DONE:
  - out_valid = 1 and out_state = `work`. Both are held stable while out_ready = 0.
  - On out_ready, go to IDLE. in_valid is not sampled in the same cycle.
- in_ready is 0 in RUN and DONE; in_valid is ignored there.
- out_state is driven from `work` at all times. It is meaningful only while out_valid = 1.
- LANES = 16: RUN lasts exactly one cycle and `beat` stays 0.
- Reset, at any time including mid-RUN or in DONE:
  - Asynchronously forces state to IDLE, `beat` to 0 and `work` to 0.
  - The block in flight is discarded and no out_valid pulse is produced.
- Reset values: in_ready = 1, out_valid = 0, busy = 0, out_state = 0.

## Timing
- Latency: out_valid rises NBEATS rising edges after the accepting edge (LANES=4 gives 4 cycles; LANES=1 gives 16).
- Throughput: one block per NBEATS+2 cycles with out_ready held high (accept edge, NBEATS RUN edges, DONE→IDLE edge). There is no overlap between consecutive blocks.
- in_ready, out_valid and busy are pure decodes of the registered FSM state. There is no combinational path from in_valid or out_ready to any output.
- The sbox path is combinational within one cycle: a LANES-wide byte mux feeds the sbox, whose output drives the write-back mux into `work`.

## Structure
- Shared package `aes_pkg`:
  - AES_BLOCK_BYTES = 16.
  - Typedef `aes_state_t` (logic [127:0]).
  - Enum `inv_sb_fsm_e` {IDLE, RUN, DONE}.
- Existing sub-module `aes_inv_sbox` is instantiated LANES times in a generate loop. No new sub-module is needed.
- Byte select and write-back use the constant index beat*LANES+lane. There are no variable part-selects wider than one byte.

## Test plan
- **Reset:** hold rst_n low 3 cycles, then release → in_ready = 1, out_valid = 0, busy = 0, out_state = 0.
- **LANES=4, uniform input:** in_state = 16×0x63 → out_valid exactly 4 cycles after the accepting edge, out_state = 16×0x00. Then in_state = 16×0x00 → out_state = 16×0x52.
- **Byte order, all legal LANES:** in_state = {0x00,0xff,0x63,0x7c} repeated 4× → out_state = {0x52,0x7d,0x00,0x01} repeated 4×. Latency equals 16/LANES cycles for each of LANES = 1, 2, 4, 8, 16.
- **Backpressure:** hold out_ready = 0 for 10 cycles in DONE while toggling in_valid → out_valid and out_state stay constant, in_ready = 0, no new capture. Raise out_ready → IDLE on the next edge, in_ready = 1.
- **Reset mid-RUN:** pulse rst_n low during RUN beat 2 (LANES=1) → out_valid never asserts for that block. The next block, 16×0x63, produces 16×0x00 with nominal latency.
- **Exhaustive:** 16 back-to-back blocks covering input bytes 0x00…0xff, each block holding 16 consecutive values → every output byte matches the 256-entry inverse S-box golden table. Random out_ready stalls are inserted and no mismatch is allowed.
